// File: rtl/sprite_layer.sv
// -----------------------------------------------------------------------------
// sprite_layer
//
// Renders one SPRITE_W x SPRITE_H sprite at a movable screen position with
// power-of-2 magnification, multi-frame animation and a transparent colour
// index. Pixels are fetched from an external synchronous ROM that holds all
// animation frames back to back.
//
// Pipeline (fixed 3-cycle latency from DrawX/DrawY/blank to pixel outputs):
//   n   : DrawX/DrawY/blank sampled, box test and address computed
//   n+1 : rom_address registered
//   n+2 : rom_q returned by the ROM
//   n+3 : pixel_index / pixel_hit registered
//
// Position and scale are shadowed on frame_start so a frame never tears.
//
// Optional build macro: SPRITE_LAYER_MIRROR_EN
//   When defined, adds input mirror_x (shadowed on frame_start) that flips
//   the sprite horizontally. When undefined the port does not exist.
//
// Ports:
//   vga_clk      in   pixel clock, all logic on posedge
//   reset_n      in   asynchronous active-low reset
//   DrawX/DrawY  in   current pixel column / row (10 bit)
//   blank        in   1 = active display region
//   frame_start  in   one-cycle pulse at start of frame
//   pos_x/pos_y  in   requested sprite left / top edge
//   scale        in   magnification shift 0..3 (x1..x8)
//   anim_en      in   1 = animation advances
//   mirror_x     in   horizontal flip (SPRITE_LAYER_MIRROR_EN only)
//   rom_address  out  registered sprite ROM address
//   rom_q        in   ROM data, valid one cycle after rom_address
//   pixel_index  out  sprite colour index (0 when no hit)
//   pixel_hit    out  1 = opaque sprite pixel
//   anim_frame   out  current animation frame
// -----------------------------------------------------------------------------
module sprite_layer #(
    parameter int SPRITE_W    = 32,
    parameter int SPRITE_H    = 32,
    parameter int FRAMES      = 4,
    parameter int INDEX_W     = 3,
    parameter int TRANSPARENT = 0,
    parameter int FRAME_HOLD  = 8,
    localparam int ROM_AW     = $clog2(FRAMES * SPRITE_W * SPRITE_H),
    localparam int FRAME_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               frame_start,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [1:0]         scale,
    input  logic               anim_en,
`ifdef SPRITE_LAYER_MIRROR_EN
    input  logic               mirror_x,
`endif
    output logic [ROM_AW-1:0]  rom_address,
    input  logic [INDEX_W-1:0] rom_q,
    output logic [INDEX_W-1:0] pixel_index,
    output logic               pixel_hit,
    output logic [FRAME_W-1:0] anim_frame
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    // Shadowed geometry and animation state
    logic [9:0]         r_sx;
    logic [9:0]         r_sy;
    logic [1:0]         r_sscale;
    logic               r_smirror;
    logic [HOLD_W-1:0]  r_hold;
    logic [FRAME_W-1:0] r_anim_frame;

    // Pipeline registers
    logic [ROM_AW-1:0]  r_rom_address;
    logic               r_in_box_d1;
    logic               r_blank_d1;
    logic               r_in_box_d2;
    logic               r_blank_d2;
    logic [INDEX_W-1:0] r_pixel_index;
    logic               r_pixel_hit;

    // Stage-0 combinational results
    logic [10:0]        w_dx;
    logic [10:0]        w_dy;
    logic [31:0]        w_wlim;
    logic [31:0]        w_hlim;
    logic [9:0]         w_lx;
    logic [9:0]         w_lx_eff;
    logic [9:0]         w_ly;
    logic               w_in_box;
    logic [ROM_AW-1:0]  w_addr;
    logic               w_mirror_in;
    logic               w_opaque;

`ifdef SPRITE_LAYER_MIRROR_EN
    assign w_mirror_in = mirror_x;
`else
    assign w_mirror_in = 1'b0;
`endif

    // Stage 0: box test against the shadowed position and sprite-local address.
    // The 11-bit subtraction exposes a borrow so pixels left of / above the
    // sprite never wrap around into it.
    always_comb begin
        w_dx     = {1'b0, DrawX} - {1'b0, r_sx};
        w_dy     = {1'b0, DrawY} - {1'b0, r_sy};
        w_wlim   = 32'(SPRITE_W) << r_sscale;
        w_hlim   = 32'(SPRITE_H) << r_sscale;
        w_lx     = w_dx[9:0] >> r_sscale;
        w_ly     = w_dy[9:0] >> r_sscale;
        w_in_box = 1'b0;
        if (!w_dx[10] && !w_dy[10] &&
            ({22'd0, w_dx[9:0]} < w_wlim) && ({22'd0, w_dy[9:0]} < w_hlim)) begin
            w_in_box = 1'b1;
        end else begin
            w_in_box = 1'b0;
        end
        if (r_smirror) begin
            w_lx_eff = 10'(SPRITE_W - 1) - w_lx;
        end else begin
            w_lx_eff = w_lx;
        end
        // Products are formed at ROM_AW width, which equals truncating the
        // full-width address.
        w_addr = ROM_AW'(r_anim_frame) * ROM_AW'(SPRITE_W * SPRITE_H)
               + ROM_AW'(w_ly) * ROM_AW'(SPRITE_W)
               + ROM_AW'(w_lx_eff);
        w_opaque = (rom_q != INDEX_W'(TRANSPARENT));
    end

    // Shadow capture of position, scale and mirror on frame_start only
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sx      <= 10'd0;
            r_sy      <= 10'd0;
            r_sscale  <= 2'd0;
            r_smirror <= 1'b0;
        end else if (frame_start) begin
            r_sx      <= pos_x;
            r_sy      <= pos_y;
            r_sscale  <= scale;
            r_smirror <= w_mirror_in;
        end else begin
            r_sx      <= r_sx;
            r_sy      <= r_sy;
            r_sscale  <= r_sscale;
            r_smirror <= r_smirror;
        end
    end

    // Animation: hold counter counts enabled frame_starts, frame advances on wrap
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold       <= {HOLD_W{1'b0}};
            r_anim_frame <= {FRAME_W{1'b0}};
        end else if (frame_start && anim_en) begin
            if (r_hold == HOLD_W'(FRAME_HOLD - 1)) begin
                r_hold <= {HOLD_W{1'b0}};
                if (r_anim_frame == FRAME_W'(FRAMES - 1)) begin
                    r_anim_frame <= {FRAME_W{1'b0}};
                end else begin
                    r_anim_frame <= r_anim_frame + FRAME_W'(1);
                end
            end else begin
                r_hold <= r_hold + HOLD_W'(1);
            end
        end else begin
            r_hold       <= r_hold;
            r_anim_frame <= r_anim_frame;
        end
    end

    // Stage 1/2: ROM address and the in_box/blank flags that travel with it
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_address <= {ROM_AW{1'b0}};
            r_in_box_d1   <= 1'b0;
            r_blank_d1    <= 1'b0;
            r_in_box_d2   <= 1'b0;
            r_blank_d2    <= 1'b0;
        end else begin
            r_rom_address <= w_in_box ? w_addr : {ROM_AW{1'b0}};
            r_in_box_d1   <= w_in_box;
            r_blank_d1    <= blank;
            r_in_box_d2   <= r_in_box_d1;
            r_blank_d2    <= r_blank_d1;
        end
    end

    // Stage 3: register hit/index from the returned ROM word
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel_hit   <= 1'b0;
            r_pixel_index <= {INDEX_W{1'b0}};
        end else if (r_in_box_d2 && r_blank_d2 && w_opaque) begin
            r_pixel_hit   <= 1'b1;
            r_pixel_index <= rom_q;
        end else begin
            r_pixel_hit   <= 1'b0;
            r_pixel_index <= {INDEX_W{1'b0}};
        end
    end

    assign rom_address = r_rom_address;
    assign pixel_index = r_pixel_index;
    assign pixel_hit   = r_pixel_hit;
    assign anim_frame  = r_anim_frame;

endmodule

// File: tb/tb_sprite_layer.sv
// -----------------------------------------------------------------------------
// tb_sprite_layer
//
// Self-checking bench for sprite_layer (W=H=32, FRAMES=4, FRAME_HOLD=8).
// A synchronous ROM model with random contents feeds the DUT. A reference
// model computes, from plain screen arithmetic, the expected ROM address one
// cycle later and the expected hit/index three cycles later, and the expected
// animation frame from the count of enabled frame_start pulses.
// Honours SPRITE_LAYER_MIRROR_EN when defined.
// -----------------------------------------------------------------------------
module tb_sprite_layer;

    localparam int W    = 32;
    localparam int H    = 32;
    localparam int FR   = 4;
    localparam int HOLD = 8;
    localparam int DEPTH = FR * W * H;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        blank = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  pos_x = 10'd0;
    logic [9:0]  pos_y = 10'd0;
    logic [1:0]  scale = 2'd0;
    logic        anim_en = 1'b0;
    logic        mirror_x = 1'b0;
    logic [11:0] rom_address;
    logic [2:0]  rom_q = 3'd0;
    logic [2:0]  pixel_index;
    logic        pixel_hit;
    logic [1:0]  anim_frame;

    logic [2:0]  rom_mem [0:DEPTH-1];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_sx, m_sy, m_sc, m_mx, m_nen;
    int q_hit[$];
    int q_idx[$];
    int exp_addr;

    // persistent stimulus settings
    int g_px, g_py, g_sc, g_ae, g_mx;

    sprite_layer #(
        .SPRITE_W(W), .SPRITE_H(H), .FRAMES(FR), .INDEX_W(3),
        .TRANSPARENT(0), .FRAME_HOLD(HOLD)
    ) dut (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .blank(blank),
        .frame_start(frame_start),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .scale(scale),
        .anim_en(anim_en),
`ifdef SPRITE_LAYER_MIRROR_EN
        .mirror_x(mirror_x),
`endif
        .rom_address(rom_address),
        .rom_q(rom_q),
        .pixel_index(pixel_index),
        .pixel_hit(pixel_hit),
        .anim_frame(anim_frame)
    );

    always #5 vga_clk = ~vga_clk;

    // synchronous sprite ROM
    always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_sx = 0; m_sy = 0; m_sc = 0; m_mx = 0; m_nen = 0;
        q_hit.delete();
        q_idx.delete();
        repeat (3) begin
            q_hit.push_back(0);
            q_idx.push_back(0);
        end
        exp_addr = 0;
    endtask

    // One pixel clock: check outputs, drive new inputs, predict their effect.
    task automatic step(input int x, input int y, input int bl, input int fs);
        int dx, dy, span, lx, ly, addr, inb, hit;
        @(negedge vga_clk);
        check_eq("rom_address", int'(rom_address), exp_addr);
        check_eq("anim_frame", int'(anim_frame), (m_nen / HOLD) % FR);
        check_eq("pixel_hit", int'(pixel_hit), q_hit.pop_front());
        check_eq("pixel_index", int'(pixel_index), q_idx.pop_front());

        DrawX       = 10'(x);
        DrawY       = 10'(y);
        blank       = 1'(bl);
        frame_start = 1'(fs);
        pos_x       = 10'(g_px);
        pos_y       = 10'(g_py);
        scale       = 2'(g_sc);
        anim_en     = 1'(g_ae);
        mirror_x    = 1'(g_mx);

        dx   = x - m_sx;
        dy   = y - m_sy;
        span = 1 << m_sc;
        inb  = (dx >= 0 && dy >= 0 && dx < W * span && dy < H * span) ? 1 : 0;
        lx   = dx / span;
        ly   = dy / span;
        if (m_mx != 0) lx = W - 1 - lx;
        addr = inb ? ((((m_nen / HOLD) % FR) * W * H + ly * W + lx) % DEPTH) : 0;
        hit  = (inb && bl && rom_mem[addr] != 3'd0) ? 1 : 0;
        q_hit.push_back(hit);
        q_idx.push_back(hit ? int'(rom_mem[addr]) : 0);
        exp_addr = addr;

        if (fs != 0) begin
            m_sx = g_px; m_sy = g_py; m_sc = g_sc;
`ifdef SPRITE_LAYER_MIRROR_EN
            m_mx = g_mx;
`endif
            if (g_ae != 0) m_nen++;
        end
    endtask

    // Asynchronous reset in the middle of a visible line
    task automatic do_reset();
        @(negedge vga_clk);
        DrawX = 10'd45; DrawY = 10'd7; blank = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_rom_address", int'(rom_address), 0);
        check_eq("rst_pixel_hit", int'(pixel_hit), 0);
        check_eq("rst_pixel_index", int'(pixel_index), 0);
        check_eq("rst_anim_frame", int'(anim_frame), 0);
        DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0; frame_start = 1'b0;
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic flush();
        repeat (4) step(0, 600, 0, 0);
    endtask

    task automatic random_run(input int n);
        int tx, ty;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                g_px = int'($urandom_range(0, 639));
                g_py = int'($urandom_range(0, 479));
                g_sc = int'($urandom_range(0, 3));
                g_ae = int'($urandom_range(0, 1));
                g_mx = int'($urandom_range(0, 1));
                step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0, 1);
            end else begin
                tx = (g_px + int'($urandom_range(0, 300)) - 20 + 1024) % 1024;
                ty = (g_py + int'($urandom_range(0, 300)) - 20 + 1024) % 1024;
                step(tx, ty, int'($urandom_range(0, 3) != 0), 0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 3'($urandom_range(0, 7));
        rom_mem[0]    = 3'd5;
        rom_mem[1]    = 3'd0;
        rom_mem[31]   = 3'd3;
        rom_mem[1024] = 3'd6;
        g_px = 0; g_py = 0; g_sc = 0; g_ae = 0; g_mx = 0;

        do_reset();
        // after reset the shadow sits at (0,0), scale 0
        step(40, 40, 1, 0);
        step(5, 5, 1, 0);
        step(31, 31, 1, 0);
        step(32, 31, 1, 0);

        // placement and latency
        g_px = 100; g_py = 50; g_sc = 0;
        step(0, 0, 0, 1);
        step(100, 50, 1, 0);
        step(101, 50, 1, 0);   // transparent word
        step(131, 50, 1, 0);
        step(132, 50, 1, 0);
        step(99, 50, 1, 0);
        step(100, 50, 0, 0);   // opaque but blanked
        step(100, 81, 1, 0);
        step(100, 82, 1, 0);
        flush();

        // scaling and right-edge clipping
        g_px = 620; g_py = 0; g_sc = 2;
        step(0, 0, 0, 1);
        for (int x = 618; x < 640; x++) step(x, 3, 1, 0);
        step(0, 3, 1, 0);
        flush();

        // animation advance and wrap, then hold with anim_en=0
        g_px = 0; g_py = 0; g_sc = 0; g_ae = 1;
        for (int i = 0; i < 36; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 1, 0);
        end
        g_ae = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 1, 0);
        end

        // tear-free position update
        g_px = 100; g_py = 10;
        step(0, 0, 0, 1);
        step(100, 10, 1, 0);
        g_px = 200;
        step(100, 10, 1, 0);
        step(200, 10, 1, 0);
        step(0, 0, 0, 1);
        step(200, 10, 1, 0);
        step(100, 10, 1, 0);

        // horizontal mirror (only changes behaviour with the mirror build)
        g_mx = 1;
        step(0, 0, 0, 1);
        step(200, 10, 1, 0);
        step(231, 10, 1, 0);
        g_mx = 0;
        step(0, 0, 0, 1);
        flush();

        random_run(2000);
        do_reset();
        random_run(400);
        flush();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_layer.md
Name: sprite_layer

Overview:
- Parametrised sprite renderer; successor to the single full-screen image-ROM block.
- Draws one W×H sprite at a movable position with integer power-of-2 scaling, multi-frame animation and a transparent colour index.
- Outputs a palette index plus a hit flag, which the downstream compositor and palette use to layer the sprite over background and other layers.
- Drives an external synchronous sprite ROM clocked on vga_clk.

Parameters:
- SPRITE_W, 32, sprite width in source pixels (power of 2).
- SPRITE_H, 32, sprite height in source pixels (power of 2).
- FRAMES, 4, number of animation frames stored back-to-back in ROM (≥1).
- INDEX_W, 3, ROM data / palette index width.
- TRANSPARENT, 0, index value treated as see-through.
- FRAME_HOLD, 8, video frames each animation frame is shown (≥1).
- ROM_AW, derived localparam, clog2(FRAMES*SPRITE_W*SPRITE_H).

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active display region.
- frame_start  in  1  one-cycle pulse at start of each frame (vertical blank).
- pos_x  in  10  requested sprite left edge, screen pixels.
- pos_y  in  10  requested sprite top edge.
- scale  in  2  magnification shift: 0=×1 … 3=×8.
- anim_en  in  1  1 = animation advances.
- rom_address  out  ROM_AW  registered sprite ROM address.
- rom_q  in  INDEX_W  ROM data, valid 1 cycle after rom_address.
- pixel_index  out  INDEX_W  sprite colour index for this pixel.
- pixel_hit  out  1  1 = opaque sprite pixel; compositor selects sprite.
- anim_frame  out  clog2(FRAMES) (min 1)  current animation frame.

Behaviour:
- Reset is asynchronous and active-low. On assertion, all of the following are 0:
  - outputs: rom_address, pixel_index, pixel_hit, anim_frame;
  - internal state: shadow pos_x/pos_y/scale, hold counter, pipeline valid flags.
- Shadow registers:
  - pos_x, pos_y and scale are captured only on a cycle with frame_start=1; no mid-frame tearing.
  - The value present in the frame_start cycle is the value used.
  - The pixel presented in the cycle after capture already uses the new shadow.
- Box test, on stage-0 inputs:
  - dx = DrawX - sx (11-bit with borrow); dy likewise.
  - in_box = no borrow on dx and dy, dx < (SPRITE_W<<sscale), and dy < (SPRITE_H<<sscale).
  - Sprite extending past column 639 or row 479 is clipped naturally; no wrap to the left or top.
- Address: lx = dx>>sscale, ly = dy>>sscale; address = anim_frame*W*H + ly*W + lx, truncated to ROM_AW.
- rom_address is registered. When !in_box it is driven to 0.
- Pipeline:
  - Cycle n: DrawX/DrawY/blank sampled.
  - n+1: rom_address valid.
  - n+2: rom_q valid.
  - n+3: pixel_index/pixel_hit registered.
  - Fixed 3-cycle latency; in_box and blank are delayed in matching flags.
- Output rule:
  - pixel_hit = in_box_d & blank_d & (rom_q != TRANSPARENT).
  - pixel_index = rom_q when pixel_hit, else 0.
- Animation:
  - On frame_start with anim_en=1, the hold counter increments.
  - When the counter is at FRAME_HOLD-1 it clears, and anim_frame increments, wrapping FRAMES-1 → 0.
  - anim_en=0: counter and anim_frame hold.
  - FRAMES=1: anim_frame is constant 0.
  - FRAME_HOLD=1: advance on every frame_start.
- anim_frame changes only on a frame_start cycle; it takes effect from the next cycle's address.
- Reset mid-frame: outputs 0 immediately; rendering resumes with pos (0,0), scale 0 until the next frame_start.

Optional Feature:
- Macro SPRITE_LAYER_MIRROR_EN.
- Defined:
  - Adds input port mirror_x (1 bit), captured into a shadow on frame_start (reset 0).
  - When the shadow is 1, lx is replaced by SPRITE_W-1-lx (horizontal flip).
  - Latency unchanged.
- Undefined: no mirror_x port; lx is never flipped.

Test Plan:
- Configuration for all cases: W=H=32, FRAMES=4, FRAME_HOLD=8.
- Reset: hold reset_n=0 mid-line with blank=1 → rom_address=0, pixel_hit=0, anim_frame=0 asynchronously. After release, pixel_hit stays 0 until the drawn region overlaps (0,0)..(31,31).
- Placement/latency: pos=(100,50), scale=0, frame_start, then DrawX=100, DrawY=50 at cycle n → rom_address=0 at n+1; pixel_hit/pixel_index reflect ROM word 0 at n+3. DrawX=131 → address 31; DrawX=132 or 99 → hit=0.
- Scaling/clipping: scale=2, pos=(620,0) → DrawX=620..623 all map to lx=0; DrawX=639 → lx=4; no hit at DrawX=0 (no wrap).
- Transparency and blank: ROM word = TRANSPARENT (0) → hit=0, index=0. Opaque word with blank=0 → hit=0.
- Animation: anim_en=1, 8 frame_start pulses → anim_frame 0→1; the pixel at sprite origin then addresses 1024. After 32 pulses anim_frame wraps to 0. With anim_en=0, 8 pulses → no change.
- Tear-free update: change pos_x from 100 to 200 mid-frame without frame_start → hits stay at 100 until the next frame_start. With SPRITE_LAYER_MIRROR_EN and mirror_x=1, the origin pixel addresses 31.
